// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Imported by the interface, the sequencer and its counter block.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int HZ_CNT_WIDTH   = 32;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MDU_BUSY = 1'b1
  } hazard_state_e;

  // Hold/bubble pair for one pipeline register.
  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard sources from the pipeline and per-stage stall/flush strobes back to it.
// The pipeline side is the master; the hazard sequencer is the slave.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_ex_rd_addr;
  logic                      id_ex_mem_read;
  logic                      ex_mdu_start;
  logic                      mdu_done;
  logic                      ex_redirect;
  logic                      dmem_req;
  logic                      dmem_ready;

  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_stall;
  logic mem_wb_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_ex_rd_addr, id_ex_mem_read, ex_mdu_start, mdu_done,
           ex_redirect, dmem_req, dmem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_ex_rd_addr, id_ex_mem_read, ex_mdu_start, mdu_done,
           ex_redirect, dmem_req, dmem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush
  );

endinterface

// File: rtl/hazard_ctrl_perf_cnt.sv
// Stall/redirect statistics and the MDU watchdog for the hazard sequencer.
// Counters wrap; the watchdog flag is sticky until reset.
module hazard_ctrl_perf_cnt #(
  parameter int MDU_MAX_CYCLES = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_event,
  input  logic                 redirect_event,
  input  logic                 mdu_enter,
  input  logic                 mdu_busy,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] redirect_count,
  output logic                 mdu_timeout
);

  localparam int WD_W = $clog2(MDU_MAX_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MDU_MAX_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX_CYCLES - 1);

  logic [WD_W-1:0] mdu_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
      mdu_cnt        <= '0;
      mdu_timeout    <= 1'b0;
    end else begin
      if (stall_event)    stall_cycles   <= stall_cycles + CNT_WIDTH'(1);
      if (redirect_event) redirect_count <= redirect_count + CNT_WIDTH'(1);

      // Saturates at the limit so a very long wait cannot wrap back below it.
      if (mdu_enter)
        mdu_cnt <= '0;
      else if (mdu_busy && mdu_cnt != WD_MAX)
        mdu_cnt <= mdu_cnt + WD_W'(1);

      if (mdu_busy && mdu_cnt == WD_LAST) mdu_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: prioritised per-stage stall/flush strobes for
// data-memory waits, MUL/DIV occupancy, EX redirects and load-use hazards.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 64,
  parameter int CNT_WIDTH      = HZ_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_ctrl_if.slave         hz,
  output hazard_state_e        ctrl_state,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] redirect_count,
  output logic                 mdu_timeout
);

  logic       dstall;
  logic       load_use;
  logic       mdu_stall;
  logic       mdu_enter;
  logic       mdu_release;
  logic       redirect_apply;
  logic       done_pending;
  logic       pc_hold;
  pipe_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

  assign dstall   = hz.dmem_req & ~hz.dmem_ready;
  assign load_use = hz.id_ex_mem_read && (hz.id_ex_rd_addr != '0) &&
                    ((hz.id_uses_rs1 && hz.id_ex_rd_addr == hz.id_rs1_addr) ||
                     (hz.id_uses_rs2 && hz.id_ex_rd_addr == hz.id_rs2_addr));

  // A same-cycle done (1-cycle op) never stalls; the release cycle lets EX advance.
  assign mdu_enter   = (ctrl_state == S_RUN) && hz.ex_mdu_start && !hz.mdu_done;
  assign mdu_release = (ctrl_state == S_MDU_BUSY) && (hz.mdu_done || done_pending) && !dstall;
  assign mdu_stall   = mdu_enter ||
                       ((ctrl_state == S_MDU_BUSY) && !(hz.mdu_done || done_pending));

  assign redirect_apply = !dstall && !mdu_stall && hz.ex_redirect;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // branch can leave it unassigned and infer a latch.
  always_comb begin
    pc_hold  = 1'b0;
    if_id_c  = '0;
    id_ex_c  = '0;
    ex_mem_c = '0;
    mem_wb_c = '0;
    if (dstall) begin
      pc_hold        = 1'b1;
      if_id_c.stall  = 1'b1;
      id_ex_c.stall  = 1'b1;
      ex_mem_c.stall = 1'b1;
      mem_wb_c.flush = 1'b1;
    end else if (mdu_stall) begin
      pc_hold        = 1'b1;
      if_id_c.stall  = 1'b1;
      id_ex_c.stall  = 1'b1;
      ex_mem_c.flush = 1'b1;
    end else if (hz.ex_redirect) begin
      // The ID instruction is on the wrong path, so any load-use hit is moot.
      if_id_c.flush = 1'b1;
      id_ex_c.flush = 1'b1;
    end else if (load_use) begin
      pc_hold       = 1'b1;
      if_id_c.stall = 1'b1;
      id_ex_c.flush = 1'b1;
    end
  end

  // Strobes are forced quiet while reset is held, not just after the next edge.
  assign hz.pc_stall     = pc_hold        & ~rst;
  assign hz.if_id_stall  = if_id_c.stall  & ~rst;
  assign hz.id_ex_stall  = id_ex_c.stall  & ~rst;
  assign hz.ex_mem_stall = ex_mem_c.stall & ~rst;
  assign hz.mem_wb_stall = mem_wb_c.stall & ~rst;
  assign hz.if_id_flush  = if_id_c.flush  & ~rst;
  assign hz.id_ex_flush  = id_ex_c.flush  & ~rst;
  assign hz.ex_mem_flush = ex_mem_c.flush & ~rst;
  assign hz.mem_wb_flush = mem_wb_c.flush & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_state   <= S_RUN;
      done_pending <= 1'b0;
    end else begin
      unique case (ctrl_state)
        S_RUN: begin
          if (mdu_enter) ctrl_state <= S_MDU_BUSY;
        end
        S_MDU_BUSY: begin
          if (mdu_release) begin
            ctrl_state   <= S_RUN;
            done_pending <= 1'b0;
          end else if (hz.mdu_done) begin
            // Result arrived while MEM was frozen; remember it until EX can move.
            done_pending <= 1'b1;
          end
        end
        default: ctrl_state <= S_RUN;
      endcase
    end
  end

  hazard_ctrl_perf_cnt #(
    .MDU_MAX_CYCLES(MDU_MAX_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_perf_cnt (
    .clk           (clk),
    .rst           (rst),
    .stall_event   (pc_hold),
    .redirect_event(redirect_apply),
    .mdu_enter     (mdu_enter),
    .mdu_busy      (ctrl_state == S_MDU_BUSY),
    .stall_cycles  (stall_cycles),
    .redirect_count(redirect_count),
    .mdu_timeout   (mdu_timeout)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MAXC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  hazard_state_e ctrl_state;
  logic [31:0]   stall_cycles;
  logic [31:0]   redirect_count;
  logic          mdu_timeout;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.MDU_MAX_CYCLES(MAXC), .CNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .hz            (hz),
    .ctrl_state    (ctrl_state),
    .stall_cycles  (stall_cycles),
    .redirect_count(redirect_count),
    .mdu_timeout   (mdu_timeout)
  );

  always #5 clk = ~clk;

  // A MUL/DIV occupying EX can never also be a redirecting branch.
  assert property (@(posedge clk) disable iff (rst)
    !(ctrl_state == S_MDU_BUSY && hz.ex_redirect));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is an MDU op outstanding, has its result been parked,
  // how long has it been outstanding, plus the three observable statistics.
  bit          m_busy, m_pend, m_to;
  int          m_run;
  int unsigned m_stall, m_redir;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall, hz.ex_mem_stall, hz.mem_wb_stall,
            hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_to = 0; m_run = 0; m_stall = 0; m_redir = 0;
  endtask

  task automatic set_idle();
    hz.id_rs1_addr = '0; hz.id_rs2_addr = '0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
    hz.id_ex_rd_addr = '0; hz.id_ex_mem_read = 0; hz.ex_mdu_start = 0; hz.mdu_done = 0;
    hz.ex_redirect = 0; hz.dmem_req = 0; hz.dmem_ready = 1;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    bit ds, lu, bs, hit1, hit2;
    logic [8:0] e;
    #1;
    ds   = hz.dmem_req && !hz.dmem_ready;
    hit1 = hz.id_uses_rs1 && (hz.id_ex_rd_addr == hz.id_rs1_addr);
    hit2 = hz.id_uses_rs2 && (hz.id_ex_rd_addr == hz.id_rs2_addr);
    lu   = hz.id_ex_mem_read && (hz.id_ex_rd_addr != 0) && (hit1 || hit2);
    bs   = m_busy ? !(hz.mdu_done || m_pend) : (hz.ex_mdu_start && !hz.mdu_done);
    //       pc ifid idex exmem memwb | ifid idex exmem memwb
    if (ds)                  e = 9'b11110_0001;
    else if (bs)             e = 9'b11100_0010;
    else if (hz.ex_redirect) e = 9'b00000_1100;
    else if (lu)             e = 9'b11000_0100;
    else                     e = 9'b00000_0000;
    check("strobes", 64'(strobes()), 64'(e));
    check("ctrl_state", 64'(ctrl_state), 64'(m_busy ? S_MDU_BUSY : S_RUN));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    check("redirect_count", 64'(redirect_count), 64'(m_redir));
    check("mdu_timeout", 64'(mdu_timeout), 64'(m_to));
    @(posedge clk);
    if (e[8]) m_stall++;
    if (!ds && !bs && hz.ex_redirect) m_redir++;
    if (m_busy) begin
      if (m_run < MAXC) m_run++;
      if (m_run == MAXC) m_to = 1;
      if ((hz.mdu_done || m_pend) && !ds) begin
        m_busy = 0; m_pend = 0;
      end else if (hz.mdu_done) begin
        m_pend = 1;
      end
    end else if (hz.ex_mdu_start && !hz.mdu_done) begin
      m_busy = 1; m_run = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    set_idle();
    // Reset held with hazard-causing inputs: everything must stay quiet.
    hz.dmem_req = 1; hz.dmem_ready = 0; hz.ex_mdu_start = 1;
    @(negedge clk);
    check("reset_strobes", 64'(strobes()), 64'd0);
    check("reset_state", 64'(ctrl_state), 64'(S_RUN));
    check("reset_cnt", 64'(stall_cycles), 64'd0);
    set_idle();
    @(negedge clk);
    rst = 0;

    // Load-use on rs1 = x5, then the same pattern with rd = x0.
    hz.id_ex_mem_read = 1; hz.id_ex_rd_addr = 5'd5; hz.id_rs1_addr = 5'd5; hz.id_uses_rs1 = 1;
    #1;
    check("lu_strobes", 64'(strobes()), 64'(9'b11000_0100));
    tick();
    set_idle();
    tick();
    check("lu_stall_cycles", 64'(stall_cycles), 64'd1);
    hz.id_ex_mem_read = 1; hz.id_ex_rd_addr = 5'd0; hz.id_rs1_addr = 5'd0; hz.id_uses_rs1 = 1;
    #1;
    check("lu_x0_no_stall", 64'(strobes()), 64'd0);
    tick();
    set_idle();

    // Multi-cycle DIV: start, three busy cycles, release on done.
    hz.ex_mdu_start = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("div_busy_state", 64'(ctrl_state), 64'(S_MDU_BUSY));
      tick();
    end
    hz.ex_mdu_start = 0; hz.mdu_done = 1;
    #1;
    check("div_release", 64'(strobes()), 64'd0);
    tick();
    set_idle();
    check("div_stall_cycles", 64'(stall_cycles), 64'd5);
    check("div_back_run", 64'(ctrl_state), 64'(S_RUN));

    // Redirect together with load-use: the redirect wins.
    hz.ex_redirect = 1;
    hz.id_ex_mem_read = 1; hz.id_ex_rd_addr = 5'd7; hz.id_rs2_addr = 5'd7; hz.id_uses_rs2 = 1;
    #1;
    check("redir_strobes", 64'(strobes()), 64'(9'b00000_1100));
    tick();
    set_idle();
    check("redir_count", 64'(redirect_count), 64'd1);

    // MDU busy with a 3-cycle memory wait; done arrives during the 2nd.
    hz.ex_mdu_start = 1;
    tick();
    hz.ex_mdu_start = 0; hz.dmem_req = 1; hz.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      hz.mdu_done = (i == 1);
      #1;
      check("mdu_dstall_mwflush", 64'(hz.mem_wb_flush), 64'd1);
      tick();
    end
    hz.mdu_done = 0; hz.dmem_ready = 1;
    check("pending_still_busy", 64'(ctrl_state), 64'(S_MDU_BUSY));
    #1;
    check("pending_release", 64'(hz.pc_stall), 64'd0);
    tick();
    set_idle();
    check("pending_back_run", 64'(ctrl_state), 64'(S_RUN));
    check("pending_stall_cycles", 64'(stall_cycles), 64'd9);

    // Watchdog: hold the MDU busy past the limit.
    hz.ex_mdu_start = 1;
    tick();
    hz.ex_mdu_start = 0;
    for (int i = 0; i < MAXC - 1; i++) tick();
    check("wd_not_yet", 64'(mdu_timeout), 64'd0);
    tick();
    check("wd_set", 64'(mdu_timeout), 64'd1);
    hz.mdu_done = 1;
    tick();
    set_idle();
    tick();
    check("wd_sticky", 64'(mdu_timeout), 64'd1);

    // Asynchronous reset in the middle of an MDU wait with MEM stalled.
    hz.ex_mdu_start = 1;
    tick();
    hz.ex_mdu_start = 0;
    tick();
    hz.dmem_req = 1; hz.dmem_ready = 0;
    #2 rst = 1;
    #1;
    check("arst_strobes", 64'(strobes()), 64'd0);
    check("arst_state", 64'(ctrl_state), 64'(S_RUN));
    check("arst_stall_cnt", 64'(stall_cycles), 64'd0);
    check("arst_redir_cnt", 64'(redirect_count), 64'd0);
    check("arst_timeout", 64'(mdu_timeout), 64'd0);
    model_reset();
    set_idle();
    @(negedge clk);
    rst = 0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      hz.id_rs1_addr    = 5'($urandom_range(0, 3));
      hz.id_rs2_addr    = 5'($urandom_range(0, 3));
      hz.id_uses_rs1    = 1'($urandom_range(0, 1));
      hz.id_uses_rs2    = 1'($urandom_range(0, 1));
      hz.id_ex_rd_addr  = 5'($urandom_range(0, 3));
      hz.id_ex_mem_read = ($urandom_range(0, 2) == 0);
      hz.dmem_req       = ($urandom_range(0, 2) == 0);
      hz.dmem_ready     = 1'($urandom_range(0, 1));
      hz.mdu_done       = ($urandom_range(0, 5) == 0);
      hz.ex_mdu_start   = !m_busy && ($urandom_range(0, 9) == 0);
      hz.ex_redirect    = !m_busy && !hz.ex_mdu_start && ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
